// File: rtl/sram_read_drain.sv
// sram_read_drain
// Takes one wide scratchpad read row and drains it onto the DRAM write bus as a
// sequence of BEAT_W-bit write beats. Each beat carries the captured transaction
// ID and an address that advances by BEAT_W/8 bytes per beat. One row is held at
// a time; the next row is accepted only once the current one has fully drained.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   sram_res_valid    row offered by the scratchpad read port
//   sram_res_ready    row can be accepted (idle and not stalled)
//   sram_rdata        row data, element 0 in the low bits
//   dram_id           transaction ID, captured with the row
//   dram_base_addr    byte address of beat 0, captured with the row
//   num_request       beats minus one, captured with the row
//   be_stall          backend stall; freezes draining and row acceptance
//   dram_req_valid    beat presented
//   dram_req_ready    DRAM bus accepts the beat
//   dram_req_write    always 1 while a beat is presented
//   dram_req_id       captured ID
//   dram_req_addr     base + beat * BEAT_W/8, wrapping at ADDR_W bits
//   dram_wdata        current beat slice of the captured row
//   dram_req_last     final beat of the row
//   drain_done        one-cycle pulse after the final beat is accepted

module sram_read_drain #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic                                         sram_res_valid,
    output logic                                         sram_res_ready,
    input  logic [DATA_W-1:0]                            sram_rdata,
    input  logic [ID_W-1:0]                              dram_id,
    input  logic [ADDR_W-1:0]                            dram_base_addr,
    input  logic [((DATA_W/BEAT_W) > 1 ? $clog2(DATA_W/BEAT_W) : 1)-1:0] num_request,
    input  logic                                         be_stall,
    output logic                                         dram_req_valid,
    input  logic                                         dram_req_ready,
    output logic                                         dram_req_write,
    output logic [ID_W-1:0]                              dram_req_id,
    output logic [ADDR_W-1:0]                            dram_req_addr,
    output logic [BEAT_W-1:0]                            dram_wdata,
    output logic                                         dram_req_last,
    output logic                                         drain_done
);

    // DATA_W is expected to be an exact multiple of BEAT_W.
    localparam int unsigned BEATS      = DATA_W / BEAT_W;
    localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BEAT_BYTES = BEAT_W / 8;

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_row;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_num;
    logic                r_done;

    logic                w_send;
    logic                w_last_beat;
    logic                w_beat_fire;

    assign w_send      = (r_state == StSend);
    assign w_last_beat = (r_cnt == r_num);

    // Stall gates both sides so nothing moves while the backend is frozen.
    assign sram_res_ready = !w_send && !be_stall;
    assign dram_req_valid = w_send && !be_stall;
    assign dram_req_write = dram_req_valid;
    assign w_beat_fire    = dram_req_valid && dram_req_ready;

    assign dram_req_last = w_send && w_last_beat;
    assign dram_req_id   = r_id;
    // Plain ADDR_W-bit add: wraps silently past the top of the address space.
    assign dram_req_addr = r_base + (ADDR_W'(r_cnt) * ADDR_W'(BEAT_BYTES));
    assign dram_wdata    = r_row[r_cnt*BEAT_W +: BEAT_W];
    assign drain_done    = r_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_row   <= '0;
            r_id    <= '0;
            r_base  <= '0;
            r_num   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (sram_res_valid && sram_res_ready) begin
                        r_row   <= sram_rdata;
                        r_id    <= dram_id;
                        r_base  <= dram_base_addr;
                        r_num   <= num_request;
                        r_cnt   <= '0;
                        r_state <= StSend;
                    end
                end
                StSend: begin
                    if (w_beat_fire) begin
                        if (w_last_beat) begin
                            r_state <= StIdle;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_drain.sv
// tb_sram_read_drain
// Cycle-by-cycle vector table for sram_read_drain: each record holds the inputs
// driven for one cycle and the outputs expected in that cycle before the next
// rising edge. A hand-written sequence then drains a row under a patterned
// ready signal and follows the beats with a small in-order scoreboard.

module tb_sram_read_drain;

    logic         CLK;
    logic         RST;
    logic         sram_res_valid;
    logic         sram_res_ready;
    logic [511:0] sram_rdata;
    logic [7:0]   dram_id;
    logic [31:0]  dram_base_addr;
    logic [2:0]   num_request;
    logic         be_stall;
    logic         dram_req_valid;
    logic         dram_req_ready;
    logic         dram_req_write;
    logic [7:0]   dram_req_id;
    logic [31:0]  dram_req_addr;
    logic [63:0]  dram_wdata;
    logic         dram_req_last;
    logic         drain_done;

    sram_read_drain #(
        .DATA_W (512),
        .BEAT_W (64),
        .ID_W   (8),
        .ADDR_W (32)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .sram_res_valid (sram_res_valid),
        .sram_res_ready (sram_res_ready),
        .sram_rdata     (sram_rdata),
        .dram_id        (dram_id),
        .dram_base_addr (dram_base_addr),
        .num_request    (num_request),
        .be_stall       (be_stall),
        .dram_req_valid (dram_req_valid),
        .dram_req_ready (dram_req_ready),
        .dram_req_write (dram_req_write),
        .dram_req_id    (dram_req_id),
        .dram_req_addr  (dram_req_addr),
        .dram_wdata     (dram_wdata),
        .dram_req_last  (dram_req_last),
        .drain_done     (drain_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        sv;
        logic        st;
        logic        rd;
        logic [2:0]  num;
        logic [31:0] base;
        logic [7:0]  id;
        logic [1:0]  rsel;
        logic        e_rdy;
        logic        e_vld;
        logic        e_last;
        logic        e_done;
        logic        chk;
        logic [31:0] e_addr;
        logic [7:0]  e_id;
        logic [63:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Row 0: lane k = 0x1111_1111_1111_1111 * k. Row 1: lane k = 0xDEAD_BEEF_0000_0000 | k.
    function automatic logic [511:0] row_of(input logic [1:0] sel);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (sel == 2'd1) r[k*64 +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
            else             r[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic sv, input logic st, input logic rd,
                       input logic [2:0] num, input logic [31:0] base, input logic [7:0] id,
                       input logic [1:0] rsel, input logic e_rdy, input logic e_vld,
                       input logic e_last, input logic e_done, input logic chk,
                       input logic [31:0] e_addr, input logic [7:0] e_id,
                       input logic [63:0] e_data);
        vec_t v;
        v.rst = rst; v.sv = sv; v.st = st; v.rd = rd;
        v.num = num; v.base = base; v.id = id; v.rsel = rsel;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_last = e_last; v.e_done = e_done;
        v.chk = chk; v.e_addr = e_addr; v.e_id = e_id; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    task automatic beat(input logic rd, input logic last, input logic [31:0] addr,
                        input logic [7:0] id, input logic [63:0] data);
        add(1'b0, 1'b0, 1'b0, rd, 3'd0, 32'h0, 8'h0, 2'd0,
            1'b0, 1'b1, last, 1'b0, 1'b1, addr, id, data);
    endtask

    task automatic quiet(input logic e_rdy, input logic e_done);
        add(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 8'h0, 2'd0,
            e_rdy, 1'b0, 1'b0, e_done, 1'b0, 32'h0, 8'h0, 64'h0);
    endtask

    task automatic offer(input logic [2:0] num, input logic [31:0] base, input logic [7:0] id,
                         input logic [1:0] rsel, input logic e_done);
        add(1'b0, 1'b1, 1'b0, 1'b1, num, base, id, rsel,
            1'b1, 1'b0, 1'b0, e_done, 1'b0, 32'h0, 8'h0, 64'h0);
    endtask

    task automatic stall_cycle();
        add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0, 8'h0, 2'd0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
    endtask

    initial begin
        int          n;
        logic        prev_hold;
        logic [31:0] prev_addr;
        logic [63:0] prev_data;

        // Reset state: everything zero, ready high
        add(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 8'h0, 2'd0,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00, 64'h0);

        // Full row: 8 beats from 0x1000, id 0x5A
        offer(3'd7, 32'h1000, 8'h5A, 2'd0, 1'b0);
        beat(1'b1, 1'b0, 32'h1000, 8'h5A, 64'h0000_0000_0000_0000);
        beat(1'b1, 1'b0, 32'h1008, 8'h5A, 64'h1111_1111_1111_1111);
        beat(1'b1, 1'b0, 32'h1010, 8'h5A, 64'h2222_2222_2222_2222);
        beat(1'b1, 1'b0, 32'h1018, 8'h5A, 64'h3333_3333_3333_3333);
        beat(1'b1, 1'b0, 32'h1020, 8'h5A, 64'h4444_4444_4444_4444);
        beat(1'b1, 1'b0, 32'h1028, 8'h5A, 64'h5555_5555_5555_5555);
        beat(1'b1, 1'b0, 32'h1030, 8'h5A, 64'h6666_6666_6666_6666);
        beat(1'b1, 1'b1, 32'h1038, 8'h5A, 64'h7777_7777_7777_7777);
        quiet(1'b1, 1'b1);
        quiet(1'b1, 1'b0);

        // Short row: 3 beats from 0x200
        offer(3'd2, 32'h200, 8'h11, 2'd1, 1'b0);
        beat(1'b1, 1'b0, 32'h200, 8'h11, 64'hDEAD_BEEF_0000_0000);
        beat(1'b1, 1'b0, 32'h208, 8'h11, 64'hDEAD_BEEF_0000_0001);
        beat(1'b1, 1'b1, 32'h210, 8'h11, 64'hDEAD_BEEF_0000_0002);
        quiet(1'b1, 1'b1);
        quiet(1'b1, 1'b0);
        quiet(1'b1, 1'b0);

        // Backpressure: ready 1,0,0,1 ...
        offer(3'd3, 32'h3000, 8'h22, 2'd0, 1'b0);
        beat(1'b1, 1'b0, 32'h3000, 8'h22, 64'h0000_0000_0000_0000);
        beat(1'b0, 1'b0, 32'h3008, 8'h22, 64'h1111_1111_1111_1111);
        beat(1'b0, 1'b0, 32'h3008, 8'h22, 64'h1111_1111_1111_1111);
        beat(1'b1, 1'b0, 32'h3008, 8'h22, 64'h1111_1111_1111_1111);
        beat(1'b1, 1'b0, 32'h3010, 8'h22, 64'h2222_2222_2222_2222);
        beat(1'b0, 1'b1, 32'h3018, 8'h22, 64'h3333_3333_3333_3333);
        beat(1'b0, 1'b1, 32'h3018, 8'h22, 64'h3333_3333_3333_3333);
        beat(1'b1, 1'b1, 32'h3018, 8'h22, 64'h3333_3333_3333_3333);
        quiet(1'b1, 1'b1);

        // Stall for 4 cycles after beat 2
        offer(3'd7, 32'h4000, 8'h33, 2'd0, 1'b0);
        beat(1'b1, 1'b0, 32'h4000, 8'h33, 64'h0000_0000_0000_0000);
        beat(1'b1, 1'b0, 32'h4008, 8'h33, 64'h1111_1111_1111_1111);
        beat(1'b1, 1'b0, 32'h4010, 8'h33, 64'h2222_2222_2222_2222);
        stall_cycle();
        stall_cycle();
        stall_cycle();
        stall_cycle();
        beat(1'b1, 1'b0, 32'h4018, 8'h33, 64'h3333_3333_3333_3333);
        beat(1'b1, 1'b0, 32'h4020, 8'h33, 64'h4444_4444_4444_4444);
        beat(1'b1, 1'b0, 32'h4028, 8'h33, 64'h5555_5555_5555_5555);
        beat(1'b1, 1'b0, 32'h4030, 8'h33, 64'h6666_6666_6666_6666);
        beat(1'b1, 1'b1, 32'h4038, 8'h33, 64'h7777_7777_7777_7777);
        quiet(1'b1, 1'b1);
        // Row offered in idle under stall must not be taken
        add(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 32'h9000, 8'hEE, 2'd0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        quiet(1'b1, 1'b0);
        quiet(1'b1, 1'b0);

        // Back-to-back: second row offered in the drain_done cycle, with address wrap
        offer(3'd1, 32'h5000, 8'h44, 2'd1, 1'b0);
        beat(1'b1, 1'b0, 32'h5000, 8'h44, 64'hDEAD_BEEF_0000_0000);
        beat(1'b1, 1'b1, 32'h5008, 8'h44, 64'hDEAD_BEEF_0000_0001);
        offer(3'd1, 32'hFFFF_FFF8, 8'h66, 2'd0, 1'b1);
        beat(1'b1, 1'b0, 32'hFFFF_FFF8, 8'h66, 64'h0000_0000_0000_0000);
        beat(1'b1, 1'b1, 32'h0000_0000, 8'h66, 64'h1111_1111_1111_1111);
        quiet(1'b1, 1'b1);
        quiet(1'b1, 1'b0);

        // Reset for 2 cycles while beat 3 of 8 is pending
        offer(3'd7, 32'h6000, 8'h77, 2'd0, 1'b0);
        beat(1'b1, 1'b0, 32'h6000, 8'h77, 64'h0000_0000_0000_0000);
        beat(1'b1, 1'b0, 32'h6008, 8'h77, 64'h1111_1111_1111_1111);
        beat(1'b1, 1'b0, 32'h6010, 8'h77, 64'h2222_2222_2222_2222);
        add(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 8'h0, 2'd0,
            1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6018, 8'h77, 64'h3333_3333_3333_3333);
        add(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 8'h0, 2'd0,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 8'h0, 2'd0,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00, 64'h0);
        quiet(1'b1, 1'b0);

        // Initial reset
        RST = 1'b1;
        sram_res_valid = 1'b0;
        sram_rdata = '0;
        dram_id = '0;
        dram_base_addr = '0;
        num_request = '0;
        be_stall = 1'b0;
        dram_req_ready = 1'b1;
        repeat (2) @(negedge CLK);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST            = vecs[i].rst;
            sram_res_valid = vecs[i].sv;
            be_stall       = vecs[i].st;
            dram_req_ready = vecs[i].rd;
            num_request    = vecs[i].num;
            dram_base_addr = vecs[i].base;
            dram_id        = vecs[i].id;
            sram_rdata     = row_of(vecs[i].rsel);
            #1;
            check($sformatf("v%0d ready", i), 64'(sram_res_ready), 64'(vecs[i].e_rdy));
            check($sformatf("v%0d valid", i), 64'(dram_req_valid), 64'(vecs[i].e_vld));
            check($sformatf("v%0d write", i), 64'(dram_req_write), 64'(vecs[i].e_vld));
            check($sformatf("v%0d last", i), 64'(dram_req_last), 64'(vecs[i].e_last));
            check($sformatf("v%0d done", i), 64'(drain_done), 64'(vecs[i].e_done));
            if (vecs[i].chk) begin
                check($sformatf("v%0d addr", i), 64'(dram_req_addr), 64'(vecs[i].e_addr));
                check($sformatf("v%0d id", i), 64'(dram_req_id), 64'(vecs[i].e_id));
                check($sformatf("v%0d data", i), dram_wdata, vecs[i].e_data);
            end
        end

        // Hand-written drain of 5 beats under a 1,0,1,1,0,1... ready pattern
        @(negedge CLK);
        RST            = 1'b0;
        be_stall       = 1'b0;
        dram_req_ready = 1'b0;
        sram_res_valid = 1'b1;
        num_request    = 3'd4;
        dram_base_addr = 32'h7000;
        dram_id        = 8'h99;
        sram_rdata     = row_of(2'd1);
        #1;
        check("seq offer ready", 64'(sram_res_ready), 64'd1);
        n = 0;
        prev_hold = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge CLK);
            sram_res_valid = 1'b0;
            sram_rdata     = '0;
            dram_req_ready = ((cyc % 3) != 1);
            #1;
            check($sformatf("seq c%0d valid", cyc), 64'(dram_req_valid), 64'd1);
            if (dram_req_valid) begin
                if (prev_hold) begin
                    check($sformatf("seq c%0d hold addr", cyc), 64'(dram_req_addr),
                          64'(prev_addr));
                    check($sformatf("seq c%0d hold data", cyc), dram_wdata, prev_data);
                end
                check($sformatf("seq b%0d addr", n), 64'(dram_req_addr),
                      64'(32'h7000 + 32'(n) * 32'd8));
                check($sformatf("seq b%0d data", n), dram_wdata,
                      64'hDEAD_BEEF_0000_0000 | 64'(n));
                check($sformatf("seq b%0d id", n), 64'(dram_req_id), 64'h99);
                check($sformatf("seq b%0d last", n), 64'(dram_req_last), 64'(n == 4));
                prev_hold = !dram_req_ready;
                prev_addr = dram_req_addr;
                prev_data = dram_wdata;
                if (dram_req_ready) n++;
            end
        end
        check("seq beats drained", 64'(n), 64'd5);
        @(negedge CLK);
        dram_req_ready = 1'b1;
        #1;
        check("seq done", 64'(drain_done), 64'd1);
        check("seq no extra beat", 64'(dram_req_valid), 64'd0);
        check("seq ready after", 64'(sram_res_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_read_drain.md
Name: sram_read_drain

Overview:
- Write-back path counterpart of the SRAM write latch.
- Accepts one wide scratchpad read response (one row of 32 x 16-bit elements, 512 bits) and serializes it into 64-bit DRAM write beats.
- Each beat carries the transaction ID and an incrementing byte address.
- Sits between the scratchpad read port and the DRAM write bus; one row drains at a time.

Parameters:
- DATA_W, 512, width of the SRAM read row.
- BEAT_W, 64, DRAM bus beat width; DATA_W must be a multiple of BEAT_W.
- ID_W, 8, DRAM transaction ID width.
- ADDR_W, 32, DRAM byte-address width.
- Derived, not overridable: BEATS = DATA_W/BEAT_W (8); CNT_W = $clog2(BEATS) (3).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- sram_res_valid  in  1  SRAM read row available.
- sram_res_ready  out  1  block can accept a row.
- sram_rdata  in  DATA_W  row data; element 0 in bits [15:0].
- dram_id  in  ID_W  transaction ID, captured with the row.
- dram_base_addr  in  ADDR_W  byte address of beat 0, captured with the row.
- num_request  in  CNT_W  number of beats minus 1 (0 = 1 beat, 7 = 8 beats), captured with the row.
- be_stall  in  1  backend stall; freezes draining.
- dram_req_valid  out  1  beat presented.
- dram_req_ready  in  1  DRAM bus accepts the beat.
- dram_req_write  out  1  constant 1 while dram_req_valid is high, else 0.
- dram_req_id  out  ID_W  captured ID.
- dram_req_addr  out  ADDR_W  base + beat*(BEAT_W/8), modulo 2^ADDR_W.
- dram_wdata  out  BEAT_W  captured_row[beat*BEAT_W +: BEAT_W].
- dram_req_last  out  1  high on the final beat.
- drain_done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- States:
  - IDLE: no row held; waiting for a row.
  - SEND: row held; beats are being presented.
- Reset: state=IDLE, beat counter=0, row/ID/base/count registers=0, drain_done=0. All outputs read 0 except sram_res_ready, which reads 1.
  - Reset mid-SEND abandons the row; no further beats are issued.
- sram_res_ready = (state==IDLE) && !be_stall.
- IDLE->SEND on sram_res_valid && sram_res_ready.
  - Captures sram_rdata, dram_id, dram_base_addr, num_request.
  - Clears the beat counter.
- First beat is presented the cycle after capture, so row acceptance to first dram_req_valid is 1 cycle.
- In SEND: dram_req_valid = !be_stall.
  - Beat accepted on dram_req_valid && dram_req_ready.
  - Accepted beat increments the counter.
  - While be_stall is high: counter, state and captured data are held, and dram_req_valid is 0. Downstream must not treat a dropped valid as an error.
- dram_req_last = (counter == captured num_request) && state==SEND.
- Accepting the last beat returns to IDLE and sets drain_done=1 for exactly the next cycle.
  - sram_res_ready rises in that same cycle, so a new row may be captured while drain_done is high.
- Peak rate: one beat per cycle with ready held high. An N-beat row occupies N+1 cycles from capture to the return to IDLE.
- Beats beyond num_request are never issued.
  - Unused upper row bits are ignored.
  - num_request=7 uses the full row.
- Address arithmetic is ADDR_W-bit and wraps silently; e.g. base 0xFFFF_FFF8 gives beat 1 address 0x0000_0000.
- Data, ID and address outputs must not change while dram_req_valid is high and not yet accepted.
- sram_res_valid in SEND is ignored; sram_res_ready is low.

Test Plan:
- Reset check: assert RST 2 cycles mid-SEND with beat 3 of 8 pending -> next cycle state IDLE, dram_req_valid=0, sram_res_ready=1, drain_done=0.
- Full row: row with 64-bit lane k = 0x1111_1111_1111_1111*k, num_request=7, base 0x1000, id 0x5A, dram_req_ready tied 1 -> 8 consecutive beats, lanes 0..7, addresses 0x1000..0x1038, id 0x5A, last only on beat 7, drain_done one cycle later.
- Short row: num_request=2, base 0x200 -> exactly 3 beats (0x200, 0x208, 0x210), last on third beat, no fourth beat, sram_res_ready high after drain.
- Backpressure: toggle dram_req_ready 1,0,0,1 per cycle -> held beat keeps identical data/addr; each beat emitted exactly once, in order.
- Stall: assert be_stall for 4 cycles after beat 2 -> dram_req_valid=0 and no progress during the stall; resumes at beat 3; also a row offered in IDLE under be_stall is not captured.
- Back-to-back and wrap: second row offered in the drain_done cycle -> captured immediately. base 0xFFFF_FFF8, num_request=1 -> addresses 0xFFFF_FFF8 then 0x0000_0000.
